// File: rtl/div_pkg.sv
// Shared types and constants for the sequential RV32M divider.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SIGN,
        DONE
    } div_state_e;

    localparam int unsigned DIV_MAX_W = 64;

    // Most-negative two's-complement value for a w-bit word (w <= DIV_MAX_W).
    function automatic logic [DIV_MAX_W-1:0] most_neg(input int unsigned w);
        return {{(DIV_MAX_W-1){1'b0}}, 1'b1} << (w - 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, try subtracting the divisor.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             din_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0]   partial;
    logic [WIDTH+1:0] sum;
    logic             unused_hi;

    // partial - divisor as partial + ~divisor + 1; the carry out is the "no borrow" flag.
    always_comb begin
        partial  = {rem, din_bit};
        sum      = {1'b0, partial} + {1'b0, ~{1'b0, divisor}} + (WIDTH+2)'(1);
        q_bit    = sum[WIDTH+1];
        rem_next = q_bit ? sum[WIDTH-1:0] : partial[WIDTH-1:0];
    end

    assign unused_hi = sum[WIDTH] ^ partial[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit, one quotient bit per clock.
// Optional macro SEQ_DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_rs1,
    input  logic [WIDTH-1:0] i_rs2,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result
);

    localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg(WIDTH));

    div_state_e       state_q, state_d;
    div_op_e          op_in;
    logic             is_rem_q, neg_quo_q, neg_rem_q;
    logic [WIDTH-1:0] dvsr_q, rem_q, quo_q;
    logic [CNT_W-1:0] cnt_q;

    logic             is_signed, is_rem, sign_a, sign_b;
    logic             div_zero, overflow, early, special;
    logic [WIDTH-1:0] mag_a, mag_b, special_res;
    logic [WIDTH-1:0] step_rem, quo_fix, rem_fix;
    logic             step_q;

    always_comb begin
        op_in     = div_op_e'(i_op);
        is_signed = op_in inside {DIV_OP_DIV, DIV_OP_REM};
        is_rem    = op_in inside {DIV_OP_REM, DIV_OP_REMU};
        sign_a    = is_signed & i_rs1[WIDTH-1];
        sign_b    = is_signed & i_rs2[WIDTH-1];
        mag_a     = sign_a ? (~i_rs1 + WIDTH'(1)) : i_rs1;
        mag_b     = sign_b ? (~i_rs2 + WIDTH'(1)) : i_rs2;
        div_zero  = (i_rs2 == '0);
        overflow  = is_signed && (i_rs1 == MOST_NEG) && (i_rs2 == '1);
`ifdef SEQ_DIV_EARLY_OUT_EN
        early     = !div_zero && (mag_a < mag_b);
`else
        early     = 1'b0;
`endif
        special   = div_zero | overflow | early;
        if (div_zero)
            special_res = is_rem ? i_rs1 : '1;
        else if (overflow)
            special_res = is_rem ? '0 : i_rs1;
        else
            special_res = is_rem ? i_rs1 : '0;
        quo_fix   = neg_quo_q ? (~quo_q + WIDTH'(1)) : quo_q;
        rem_fix   = neg_rem_q ? (~rem_q + WIDTH'(1)) : rem_q;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .din_bit  (quo_q[WIDTH-1]),
        .divisor  (dvsr_q),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    always_comb begin
        state_d = state_q;
        if (i_flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (i_start) state_d = special ? DONE : RUN;
                RUN:     if (cnt_q == '0) state_d = SIGN;
                SIGN:    state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // quo_q starts as the dividend magnitude and fills with quotient bits from the right.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dvsr_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            o_result  <= '0;
        end else begin
            state_q <= state_d;
            if (!i_flush) begin
                unique case (state_q)
                    IDLE: if (i_start) begin
                        is_rem_q  <= is_rem;
                        neg_quo_q <= sign_a ^ sign_b;
                        neg_rem_q <= sign_a;
                        dvsr_q    <= mag_b;
                        rem_q     <= '0;
                        quo_q     <= mag_a;
                        cnt_q     <= CNT_W'(WIDTH-1);
                        if (special) o_result <= special_res;
                    end
                    RUN: begin
                        rem_q <= step_rem;
                        quo_q <= {quo_q[WIDTH-2:0], step_q};
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                    SIGN:    o_result <= is_rem_q ? rem_fix : quo_fix;
                    default: ;
                endcase
            end
        end
    end

    assign o_busy  = (state_q != IDLE);
    assign o_valid = (state_q == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=32) against an arithmetic reference model.
module tb_seq_divider;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [1:0]  i_op = 2'b00;
    logic [31:0] i_rs1 = '0;
    logic [31:0] i_rs2 = '0;
    logic        i_flush = 1'b0;
    logic        o_busy, o_valid;
    logic [31:0] o_result;

    int errors = 0;
    int checks = 0;

    seq_divider #(.WIDTH(32)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_start  (i_start),
        .i_op     (i_op),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .i_flush  (i_flush),
        .o_busy   (o_busy),
        .o_valid  (o_valid),
        .o_result (o_result)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic sgn, rem;
        sa  = a;
        sb  = b;
        sgn = (op == 2'b00) || (op == 2'b10);
        rem = op[1];
        if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : a;
            return rem ? 32'(sa % sb) : 32'(sa / sb);
        end
        return rem ? (a % b) : (a / b);
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        sgn = (op == 2'b00) || (op == 2'b10);
        if (b == 32'd0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef SEQ_DIV_EARLY_OUT_EN
        begin
            longint ma, mb;
            ma = sgn ? ((a[31]) ? -longint'($signed(a)) : longint'($signed(a))) : longint'(a);
            mb = sgn ? ((b[31]) ? -longint'($signed(b)) : longint'($signed(b))) : longint'(b);
            if (ma < mb) return 1;
        end
`endif
        return 34;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, scramble operands afterwards, watch 40 cycles for o_valid.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int nvalid);
        @(negedge i_clk);
        i_op = op; i_rs1 = a; i_rs2 = b; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0; i_rs1 = $urandom; i_rs2 = $urandom;
        res = '0; lat = 0; nvalid = 0;
        for (int k = 1; k <= 40; k++) begin
            if (o_valid === 1'b1) begin
                if (nvalid == 0) begin
                    lat = k;
                    res = o_result;
                end
                nvalid++;
            end
            @(negedge i_clk);
        end
    endtask

    task automatic op_check(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] res;
        int lat, nv;
        run_op(op, a, b, res, lat, nv);
        chk({tag, "_result"}, res, ref_result(op, a, b));
        chk({tag, "_latency"}, 32'(lat), 32'(ref_latency(op, a, b)));
        chk({tag, "_pulses"}, 32'(nv), 32'd1);
    endtask

    initial begin
        logic [31:0] prev;
        int nv, lat;

        #12;
        chk("reset_busy", {31'd0, o_busy}, 32'd0);
        chk("reset_valid", {31'd0, o_valid}, 32'd0);
        chk("reset_result", o_result, 32'd0);
        i_rst_n = 1'b1;

        op_check("divu_100_7", 2'b01, 32'd100, 32'd7);
        op_check("remu_100_7", 2'b11, 32'd100, 32'd7);
        op_check("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2);
        op_check("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        op_check("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE);
        op_check("divu_5_0", 2'b01, 32'd5, 32'd0);
        op_check("rem_5_0", 2'b10, 32'd5, 32'd0);
        op_check("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        op_check("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        op_check("divu_3_10", 2'b01, 32'd3, 32'd10);
        op_check("rem_m3_10", 2'b10, 32'hFFFF_FFFD, 32'd10);

        // Second start while busy must be ignored.
        @(negedge i_clk);
        i_op = 2'b01; i_rs1 = 32'd1000; i_rs2 = 32'd3; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        nv = 0; lat = 0; prev = '0;
        for (int k = 1; k <= 45; k++) begin
            if (k == 5) begin i_rs1 = 32'd9; i_rs2 = 32'd3; i_start = 1'b1; end
            if (k == 6) i_start = 1'b0;
            if (o_valid === 1'b1) begin
                if (nv == 0) begin lat = k; prev = o_result; end
                nv++;
            end
            @(negedge i_clk);
        end
        chk("busy_start_result", prev, 32'd333);
        chk("busy_start_latency", 32'(lat), 32'd34);
        chk("busy_start_pulses", 32'(nv), 32'd1);

        // Flush mid-run, with a simultaneous start.
        @(negedge i_clk);
        i_op = 2'b01; i_rs1 = 32'd77; i_rs2 = 32'd7; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        for (int k = 1; k < 10; k++) @(negedge i_clk);
        i_flush = 1'b1; i_start = 1'b1; i_rs1 = 32'd8; i_rs2 = 32'd0;
        @(negedge i_clk);
        i_flush = 1'b0; i_start = 1'b0;
        chk("flush_busy", {31'd0, o_busy}, 32'd0);
        nv = 0;
        for (int k = 0; k < 40; k++) begin
            if (o_valid === 1'b1) nv++;
            @(negedge i_clk);
        end
        chk("flush_pulses", 32'(nv), 32'd0);
        chk("flush_result_kept", o_result, 32'd333);

        // Asynchronous reset in the middle of RUN.
        @(negedge i_clk);
        i_op = 2'b01; i_rs1 = 32'd1000; i_rs2 = 32'd3; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        for (int k = 0; k < 5; k++) @(negedge i_clk);
        chk("pre_reset_busy", {31'd0, o_busy}, 32'd1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("mid_reset_busy", {31'd0, o_busy}, 32'd0);
        chk("mid_reset_valid", {31'd0, o_valid}, 32'd0);
        chk("mid_reset_result", o_result, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        for (int n = 0; n < 24; n++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 20);
                2:       b = 32'hFFFF_FFFF;
                3:       b = a + 32'($urandom_range(1, 5));
                default: b = $urandom;
            endcase
            op_check($sformatf("rand%0d", n), op, a, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
